// File: rtl/button_conditioner.sv
// button_conditioner
//
// Multi-channel pushbutton front end. Each channel synchronises a raw pin,
// debounces it, and derives level, press/release pulses, a toggle bit and
// long-press detection. Channels share only clock and reset.
//
// Ports:
//   clk        - system clock
//   resetn     - asynchronous active-low reset
//   in         - raw button pins (CHANNELS wide), asynchronous to clk
//   level      - debounced pressed state, 1 = pressed regardless of pin polarity
//   press      - one-cycle pulse after the debounced level rises
//   released   - one-cycle pulse after the debounced level falls
//                ("release" is a reserved word, hence the name)
//   toggle     - flips on every press
//   long_press - one-cycle pulse when a hold reaches LONG_COUNT cycles
//   held       - high from long_press until the release pulse
//
// Parameters:
//   CHANNELS    - number of independent channels (>= 1)
//   MAX_COUNT   - consecutive mismatching cycles needed to accept a new level (>= 1)
//   LONG_COUNT  - hold cycles before long_press; 0 disables long-press logic
//   ACTIVE_LOW  - 1 when the raw pin reads low while pressed
//   TOGGLE_INIT - reset value of every toggle bit

module button_conditioner #(
   parameter int CHANNELS    = 3,
   parameter int MAX_COUNT   = 511,
   parameter int LONG_COUNT  = 3000000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter bit TOGGLE_INIT = 1'b0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] released,
   output logic [CHANNELS-1:0] toggle,
   output logic [CHANNELS-1:0] long_press,
   output logic [CHANNELS-1:0] held
);

   // Debounce counter only ever reaches MAX_COUNT-1.
   localparam int CNT_W  = $clog2(MAX_COUNT + 1);
   // Hold counter only ever reaches LONG_COUNT-1; keep at least one bit.
   localparam int HOLD_W = (LONG_COUNT > 1) ? $clog2(LONG_COUNT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG
   } hold_state_t;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan

      logic             sync1;
      logic             sync2;
      logic             sample;
      logic             lvl;
      logic             lvl_next;
      logic             lvl_d;
      logic             prs;
      logic             rel;
      logic             tgl;
      logic             lp;
      logic             hld;
      logic [CNT_W-1:0] cnt;

      // Normalise polarity so sample = 1 always means "pressed".
      assign sample = sync2 ^ ACTIVE_LOW;

      // The level the debouncer will hold after this edge; the long-press
      // FSM uses it to start timing on the same edge the level rises.
      always_comb begin
         lvl_next = lvl;
         if ((sample != lvl) && (cnt == CNT_W'(MAX_COUNT - 1))) begin
            lvl_next = sample;
         end
      end

      // Synchroniser, debounce counter, edge pulses and toggle. The
      // synchroniser resets to the unpressed pin value so no spurious
      // mismatch is seen coming out of reset.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
            cnt   <= '0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            prs   <= 1'b0;
            rel   <= 1'b0;
            tgl   <= TOGGLE_INIT;
         end else begin
            sync1 <= in[i];
            sync2 <= sync1;
            if ((sample == lvl) || (cnt == CNT_W'(MAX_COUNT - 1))) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
            lvl   <= lvl_next;
            lvl_d <= lvl;
            prs   <= lvl & ~lvl_d;
            rel   <= ~lvl & lvl_d;
            if (lvl && !lvl_d) begin
               tgl <= ~tgl;
            end
         end
      end

      if (LONG_COUNT > 0) begin : g_long

         hold_state_t       state;
         logic [HOLD_W-1:0] hold;

         // Long-press FSM. Timing starts on the edge the level rises so the
         // pulse lands exactly LONG_COUNT cycles later. Leaving a pressed
         // state is keyed off the registered level so held clears on the
         // same edge the release pulse appears; if the level re-rises on
         // that very edge, timing restarts immediately.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               state <= IDLE;
               hold  <= '0;
               lp    <= 1'b0;
               hld   <= 1'b0;
            end else begin
               lp <= 1'b0;
               case (state)
                  IDLE: begin
                     if (lvl_next && !lvl) begin
                        state <= PRESSED;
                        hold  <= '0;
                     end
                  end
                  PRESSED: begin
                     if (!lvl) begin
                        state <= lvl_next ? PRESSED : IDLE;
                        hold  <= '0;
                        hld   <= 1'b0;
                     end else if (lvl_next) begin
                        if (hold == HOLD_W'(LONG_COUNT - 1)) begin
                           state <= LONG;
                           lp    <= 1'b1;
                           hld   <= 1'b1;
                        end else begin
                           hold <= hold + 1'b1;
                        end
                     end
                  end
                  LONG: begin
                     if (!lvl) begin
                        state <= lvl_next ? PRESSED : IDLE;
                        hold  <= '0;
                        hld   <= 1'b0;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     hold  <= '0;
                     hld   <= 1'b0;
                  end
               endcase
            end
         end

      end else begin : g_no_long

         assign lp  = 1'b0;
         assign hld = 1'b0;

      end

      assign level[i]      = lvl;
      assign press[i]      = prs;
      assign released[i]   = rel;
      assign toggle[i]     = tgl;
      assign long_press[i] = lp;
      assign held[i]       = hld;

   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised multi-channel successor to the single debouncer → edge_detection → T_ff chain on the iCEBreaker top level.
- Per channel: synchronise a raw pushbutton, debounce it, and produce level, press/release pulses, toggle state and long-press detection.
- Outputs drive LEDs directly and can act as run/halt or step controls for mic1_soc.
- Channels are fully independent and share only the clock and reset.

Parameters:
- CHANNELS, 3, number of independent button channels (≥1).
- MAX_COUNT, 511, consecutive mismatch cycles required to accept a new level (≥1).
- LONG_COUNT, 3000000, cycles of continuous debounced press before long_press fires; 0 disables long-press.
- ACTIVE_LOW, 1, 1 = raw input is low when pressed (BTN_N style); 0 = high when pressed.
- TOGGLE_INIT, 0, reset value of every toggle bit.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- in  input  CHANNELS  raw button pins, asynchronous to clk
- level  output  CHANNELS  debounced pressed state (1 = pressed, polarity already normalised)
- press  output  CHANNELS  one-cycle pulse on debounced press
- release  output  CHANNELS  one-cycle pulse on debounced release
- toggle  output  CHANNELS  flips on each press
- long_press  output  CHANNELS  one-cycle pulse when hold reaches LONG_COUNT
- held  output  CHANNELS  high from long_press until release

Behaviour:
- Reset (resetn low, async): synchronisers and level reset to the unpressed value; counters 0; press, release, long_press, held all 0; toggle = TOGGLE_INIT. Outputs stay stable while resetn is low. Reset asserted mid-count abandons the count with no pulse.
- Synchroniser: 2-flop chain per channel. Normalised sample s = sync ^ ACTIVE_LOW, so s = 1 means pressed.
- Debounce counter per channel, width clog2(MAX_COUNT+1):
  - s == level → counter cleared.
  - s != level → counter increments.
  - When counter == MAX_COUNT-1 and mismatch persists → level <= s, counter <= 0.
  - Any glitch shorter than MAX_COUNT synchronised cycles leaves level unchanged.
- Latency: raw changes before edge N and stays → level changes at edge N+MAX_COUNT+1.
- Edge pulses are registered from level vs level_d:
  - press high for exactly one cycle after the edge at which level rose, i.e. asserted at edge N+MAX_COUNT+2.
  - release is the same on a fall.
  - press and release are never high together.
- Toggle flips at the same edge press asserts.
- Long-press FSM per channel, states IDLE, PRESSED, LONG:
  - IDLE → PRESSED when level rises; hold counter <= 0.
  - PRESSED: hold counter increments each cycle while level = 1. On reaching LONG_COUNT-1 → LONG, long_press pulses one cycle, held <= 1.
  - LONG: hold counter frozen (saturated, no wrap); held stays 1.
  - Any state → IDLE when level falls; held <= 0 at the same edge release asserts.
  - LONG_COUNT = 0: FSM stays in IDLE; long_press and held constantly 0.
- Simultaneous events: a channel cannot press and release in the same cycle, since level changes at most once per MAX_COUNT cycles. Different channels may pulse in the same cycle independently.
- Counter widths are sized from the parameters; counters never overflow.

Test Plan (CHANNELS=3, MAX_COUNT=4, LONG_COUNT=10, ACTIVE_LOW=1, TOGGLE_INIT=0):
1. Reset then idle: in=3'b111, hold resetn low 3 cycles, release → level=0, toggle=0, all pulses 0 indefinitely.
2. Clean press: in[0] 1→0 before edge N and held → level[0] rises at edge N+5; press[0] is one cycle wide at edge N+6; toggle[0]=1; channels 1 and 2 stay 0.
3. Bounce rejection: in[1] low for 3 cycles, high 2, low 3, then high → level[1], press[1] and toggle[1] never change.
4. Long press and release: in[2] held low 30 cycles → long_press[2] is a single pulse exactly 10 cycles after level[2] rises; held[2]=1 until release. Then raise in[2] → release[2] pulses, held[2] clears on the same edge, and no second long_press appears.
5. Simultaneous channels: press in[0] and in[1] on the same cycle → press[1:0]=2'b11 pulse together. A second press on ch0 returns toggle[0] to 0.
6. Reset mid-count: assert resetn low 2 cycles into a debounce of ch0 → no press. After release of reset with in[0] still low, level[0] rises MAX_COUNT+1 cycles later.
